seg7_reg_viewer: RTL and testbench

// - Debug front-end downstream of the multi-cycle CPU top; drives its register-file debug read port.
// - Selects a register address with two push-buttons and feeds it to the CPU's debug address input.
// - Captures the returned 32-bit word and scans it as 8 hex digits on a multiplexed 7-segment display.

---
 rtl/seg7_reg_viewer_if.sv | 37 +++
 rtl/seg7_reg_viewer.sv | 141 ++++++++++++++
 tb/tb_seg7_reg_viewer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/seg7_reg_viewer_if.sv
// Button, register-file debug port and 7-segment signals of the register viewer.
// Optional auto_en input exists only when AUTO_STEP_EN is defined.
interface seg7_reg_viewer_if;
  logic        btn_next;
  logic        btn_prev;
`ifdef AUTO_STEP_EN
  logic        auto_en;
`endif
  logic [31:0] reg_data;
  logic [4:0]  reg_addr;
  logic [7:0]  seg_an;
  logic [7:0]  seg_cat;

  modport master (
    input  btn_next,
    input  btn_prev,
`ifdef AUTO_STEP_EN
    input  auto_en,
`endif
    input  reg_data,
    output reg_addr,
    output seg_an,
    output seg_cat
  );

  modport slave (
    output btn_next,
    output btn_prev,
`ifdef AUTO_STEP_EN
    output auto_en,
`endif
    output reg_data,
    input  reg_addr,
    input  seg_an,
    input  seg_cat
  );
endinterface

// File: rtl/seg7_reg_viewer.sv
// Register-file viewer: debounced buttons pick reg_addr, the returned word scans as 8 hex digits.
// Optional timed auto-stepping of the address is built when AUTO_STEP_EN is defined.
module seg7_reg_viewer #(
  parameter int DEB_CYCLES = 1000000,
  parameter int SCAN_DIV   = 17
`ifdef AUTO_STEP_EN
  , parameter int AUTO_DIV = 26
`endif
) (
  input  logic clk,
  input  logic rst,
  seg7_reg_viewer_if.master bus
);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WAIT_HI, HELD, WAIT_LO} deb_state_t;

  logic [1:0]          sync1, sync2;
  logic [1:0]          pulse;
  logic [4:0]          addr_r, addr_nx;
  logic                chg1, chg2;
  logic [31:0]         shadow;
  logic [SCAN_DIV-1:0] scan_cnt;
  logic [7:0]          an_r, cat_r;
  logic [2:0]          idx;
  logic [3:0]          nib;
  logic [7:0]          glyph;
  logic                dp_n;
  logic                press;

  function automatic logic [7:0] hex8(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  // bit 0 = next, bit 1 = prev
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= {bus.btn_prev, bus.btn_next};
      sync2 <= sync1;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_deb
    deb_state_t     st, st_nx;
    logic [CW-1:0]  cnt;
    logic           done;

    assign done = (cnt == CW'(DEB_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st  <= IDLE;
        cnt <= '0;
      end else begin
        st  <= st_nx;
        cnt <= (st_nx != st || st == IDLE || st == HELD) ? '0 : cnt + 1'b1;
      end
    end

    always_comb begin
      st_nx = st;
      case (st)
        IDLE:    if (sync2[b])        st_nx = WAIT_HI;
        WAIT_HI: if (!sync2[b])       st_nx = IDLE;
                 else if (done)       st_nx = HELD;
        HELD:    if (!sync2[b])       st_nx = WAIT_LO;
        WAIT_LO: if (sync2[b])        st_nx = HELD;
                 else if (done)       st_nx = IDLE;
        default:                      st_nx = IDLE;
      endcase
    end

    always_comb begin
      pulse[b] = (st == WAIT_HI) && sync2[b] && done;
    end
  end

  assign press = pulse[0] | pulse[1];

`ifdef AUTO_STEP_EN
  logic [AUTO_DIV-1:0] auto_tmr;
  logic                auto_wrap;

  assign auto_wrap = bus.auto_en && (auto_tmr == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       auto_tmr <= '0;
    else if (press || !bus.auto_en) auto_tmr <= '0;
    else                           auto_tmr <= auto_tmr + 1'b1;
  end
`endif

  // Simultaneous next/prev cancel; a press always outranks the timer.
  always_comb begin
    addr_nx = addr_r;
    if (pulse[0] && !pulse[1])      addr_nx = addr_r + 5'd1;
    else if (pulse[1] && !pulse[0]) addr_nx = addr_r - 5'd1;
`ifdef AUTO_STEP_EN
    else if (!press && auto_wrap)   addr_nx = addr_r + 5'd1;
`endif
  end

  assign idx   = scan_cnt[SCAN_DIV-1 -: 3];
  assign nib   = shadow[{idx, 2'b00} +: 4];
  assign glyph = hex8(nib);
  assign dp_n  = !(idx == 3'd7 && addr_r == 5'd0);

  // chg2 marks the second cycle after an address change, once read data has settled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r   <= 5'd0;
      chg1     <= 1'b0;
      chg2     <= 1'b0;
      shadow   <= 32'd0;
      scan_cnt <= '0;
      an_r     <= 8'hFF;
      cat_r    <= 8'hFF;
    end else begin
      addr_r   <= addr_nx;
      chg1     <= (addr_nx != addr_r);
      chg2     <= chg1;
      scan_cnt <= scan_cnt + 1'b1;
      if (chg2 || scan_cnt == '1)
        shadow <= bus.reg_data;
      an_r     <= ~(8'b1 << idx);
      cat_r    <= {dp_n, glyph[6:0]};
    end
  end

  assign bus.reg_addr = addr_r;
  assign bus.seg_an   = an_r;
  assign bus.seg_cat  = cat_r;
endmodule

// File: tb/tb_seg7_reg_viewer.sv
// Scoreboard bench: stimulus queues expected address steps and digit glyphs, a negedge monitor checks them.
module tb_seg7_reg_viewer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  logic [4:0] last_addr = 5'd0;

  typedef struct {
    logic [7:0] an;
    logic [7:0] cat;
  } disp_t;

  logic [4:0] addr_q[$];
  disp_t      disp_q[$];

  seg7_reg_viewer_if bus();

`ifdef AUTO_STEP_EN
  seg7_reg_viewer #(.DEB_CYCLES(4), .SCAN_DIV(6), .AUTO_DIV(5)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  seg7_reg_viewer #(.DEB_CYCLES(4), .SCAN_DIV(6)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // register-file model with one cycle of read latency
  always @(posedge clk) bus.reg_data <= (bus.reg_addr == 5'd1) ? 32'h1234ABCD : 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.reg_addr !== last_addr) begin
        if (addr_q.size() == 0) chk("addr_unexpected", {27'd0, bus.reg_addr}, {27'd0, last_addr});
        else                    chk("addr_step", {27'd0, bus.reg_addr}, {27'd0, addr_q.pop_front()});
        last_addr = bus.reg_addr;
      end
      if (disp_q.size() > 0) begin
        chk("an_onehot", {31'd0, $onehot(~bus.seg_an)}, 32'd1);
        if (bus.seg_an === disp_q[0].an) begin
          disp_t e;
          e = disp_q.pop_front();
          chk("digit_cat", {24'd0, bus.seg_cat}, {24'd0, e.cat});
        end
      end
    end
  end

  task automatic press(input bit nxt, input bit prv);
    bus.btn_next = nxt;
    bus.btn_prev = prv;
    repeat (10) @(negedge clk);
    bus.btn_next = 1'b0;
    bus.btn_prev = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((addr_q.size() != 0 || disp_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_addr_q", addr_q.size(), 0);
    chk("drain_disp_q", disp_q.size(), 0);
    addr_q.delete();
    disp_q.delete();
  endtask

  task automatic push_disp(input logic [7:0] c0, c1, c2, c3, c4, c5, c6, c7);
    logic [7:0] cats[8];
    cats = '{c0, c1, c2, c3, c4, c5, c6, c7};
    for (int i = 0; i < 8; i++) begin
      disp_t d;
      d.an  = ~(8'b1 << i);
      d.cat = cats[i];
      disp_q.push_back(d);
    end
  endtask

`ifdef AUTO_STEP_EN
  task automatic wait_change(output int t);
    logic [4:0] prev = bus.reg_addr;
    int n = 0;
    t = -1;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (bus.reg_addr !== prev) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) chk("auto_timeout", 32'd1, 32'd0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.btn_next = 1'b0;
    bus.btn_prev = 1'b0;
`ifdef AUTO_STEP_EN
    bus.auto_en  = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_addr", {27'd0, bus.reg_addr}, 32'd0);
    chk("rst_an",   {24'd0, bus.seg_an},   32'hFF);
    chk("rst_cat",  {24'd0, bus.seg_cat},  32'hFF);
    rst = 1'b0;
    last_addr = 5'd0;
    mon_en = 1'b1;

    for (int i = 1; i <= 5; i++) begin
      addr_q.push_back(5'(i));
      press(1'b1, 1'b0);
    end
    drain();

    // reset in the middle of a scan frame
    repeat (13) @(negedge clk);
    addr_q.push_back(5'd0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_addr", {27'd0, bus.reg_addr}, 32'd0);
    chk("midrst_an",   {24'd0, bus.seg_an},   32'hFF);
    chk("midrst_cat",  {24'd0, bus.seg_cat},  32'hFF);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_digit0", {24'd0, bus.seg_an}, 32'hFE);
    drain();

    // short glitch must be ignored, the long hold gives one step
    addr_q.push_back(5'd1);
    bus.btn_next = 1'b1;
    repeat (3) @(negedge clk);
    bus.btn_next = 1'b0;
    repeat (3) @(negedge clk);
    bus.btn_next = 1'b1;
    repeat (10) @(negedge clk);
    bus.btn_next = 1'b0;
    repeat (10) @(negedge clk);
    drain();
    chk("glitch_addr", {27'd0, bus.reg_addr}, 32'd1);

    repeat (5) @(negedge clk);
    push_disp(8'hA1, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9);
    drain();

    addr_q.push_back(5'd0);
    press(1'b0, 1'b1);
    drain();
    repeat (5) @(negedge clk);
    push_disp(8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h40);
    drain();

    addr_q.push_back(5'd31);
    press(1'b0, 1'b1);
    addr_q.push_back(5'd0);
    press(1'b1, 1'b0);
    addr_q.push_back(5'd31);
    press(1'b0, 1'b1);
    drain();
    press(1'b1, 1'b1);
    repeat (10) @(negedge clk);
    chk("both_addr", {27'd0, bus.reg_addr}, 32'd31);

`ifdef AUTO_STEP_EN
    begin
      int t0, t1, t2, tp, t3;
      addr_q.push_back(5'd0);
      rst = 1'b1;
      bus.auto_en = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      t0 = cyc;
      addr_q.push_back(5'd1);
      wait_change(t1);
      chk("auto_int1", t1 - t0, 32);
      addr_q.push_back(5'd2);
      wait_change(t2);
      chk("auto_int2", t2 - t1, 32);
      repeat (6) @(negedge clk);
      addr_q.push_back(5'd3);
      bus.btn_next = 1'b1;
      wait_change(tp);
      bus.btn_next = 1'b0;
      chk("press_before_wrap", (tp - t2) < 32, 1);
      addr_q.push_back(5'd4);
      wait_change(t3);
      chk("auto_restart", t3 - tp, 32);
      bus.auto_en = 1'b0;
      drain();
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
